// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter (data stage, fetch) for a single memory port.
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed data priority.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  d_re,
   input  logic [DATA_W/8-1:0]   d_we,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_din,
   output logic [DATA_W-1:0]     d_dout,
   output logic                  d_stall,
   input  logic                  i_re,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic [DATA_W-1:0]     i_dout,
   output logic                  i_stall,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_rw,
   output logic [ADDR_W-1:0]     mem_req_addr,
   output logic [DATA_W-1:0]     mem_req_data,
   output logic [DATA_W/8-1:0]   mem_req_mask,
   input  logic                  mem_resp_valid,
   input  logic [DATA_W-1:0]     mem_resp_data
);

   localparam int unsigned MW = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_e;

   state_e              state_q;
   logic                owner_q;
   logic                valid_q;
   logic                rw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [MW-1:0]       mask_q;
   logic [DATA_W-1:0]   d_dout_q;
   logic [DATA_W-1:0]   i_dout_q;

   logic d_req;
   logic i_req;
   logic d_wr;
   logic grant_i_d;
   logic done_d;
   logic done_i;

   assign d_wr  = |d_we;
   assign d_req = d_re | d_wr;
   assign i_req = i_re;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   // rr_q set means fetch is preferred when both request.
   logic rr_q;
   assign grant_i_d = i_req & (~d_req | rr_q);
`else
   assign grant_i_d = i_req & ~d_req;
`endif

   assign done_d  = (state_q == S_DONE) & ~owner_q;
   assign done_i  = (state_q == S_DONE) & owner_q;
   assign d_stall = d_req & ~done_d;
   assign i_stall = i_req & ~done_i;

   assign d_dout        = d_dout_q;
   assign i_dout        = i_dout_q;
   assign mem_req_valid = valid_q;
   assign mem_req_rw    = rw_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_data  = data_q;
   assign mem_req_mask  = mask_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         valid_q  <= 1'b0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         mask_q   <= '0;
         d_dout_q <= '0;
         i_dout_q <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         rr_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (d_req | i_req) begin
                  owner_q <= grant_i_d;
                  valid_q <= 1'b1;
                  state_q <= S_ISSUE;
                  if (grant_i_d) begin
                     rw_q   <= 1'b0;
                     addr_q <= i_addr;
                     data_q <= '0;
                     mask_q <= '0;
                  end else begin
                     rw_q   <= d_wr;
                     addr_q <= d_addr;
                     data_q <= d_wr ? d_din : '0;
                     mask_q <= d_we;
                  end
               end
            end
            S_ISSUE: begin
               if (mem_req_ready) begin
                  valid_q <= 1'b0;
                  if (rw_q) begin
                     state_q <= S_DONE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                     rr_q    <= ~owner_q;
`endif
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  if (owner_q) i_dout_q <= mem_resp_data;
                  else         d_dout_q <= mem_resp_data;
                  state_q <= S_DONE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                  rr_q    <= ~owner_q;
`endif
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: writes, reads, arbitration, reset abort.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        d_re;
   logic [3:0]  d_we;
   logic [31:0] d_addr;
   logic [31:0] d_din;
   logic [31:0] d_dout;
   logic        d_stall;
   logic        i_re;
   logic [31:0] i_addr;
   logic [31:0] i_dout;
   logic        i_stall;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_rw;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [3:0]  mem_req_mask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int n_chk;
   int n_fail;

   dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .d_re           (d_re),
      .d_we           (d_we),
      .d_addr         (d_addr),
      .d_din          (d_din),
      .d_dout         (d_dout),
      .d_stall        (d_stall),
      .i_re           (i_re),
      .i_addr         (i_addr),
      .i_dout         (i_dout),
      .i_stall        (i_stall),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_rw     (mem_req_rw),
      .mem_req_addr   (mem_req_addr),
      .mem_req_data   (mem_req_data),
      .mem_req_mask   (mem_req_mask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      d_re = 0; d_we = 0; d_addr = 0; d_din = 0;
      i_re = 0; i_addr = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      #2;
      n_chk++;
      if ({mem_req_valid, mem_req_rw, d_stall, i_stall} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 0000",
                  {mem_req_valid, mem_req_rw, d_stall, i_stall});
      end
      n_chk++;
      if ({mem_req_addr, mem_req_data, mem_req_mask, d_dout, i_dout} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: addr %h data %h mask %h d %h i %h want 0",
                  mem_req_addr, mem_req_data, mem_req_mask, d_dout, i_dout);
      end
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_data_write();
      d_we = 4'hF; d_addr = 32'h100; d_din = 32'hDEADBEEF;
      mem_req_ready = 1;
      #1;
      n_chk++;
      if ({d_stall, mem_req_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL wr_idle: stall,valid %b want 10", {d_stall, mem_req_valid});
      end
      tick();
      n_chk++;
      if ({mem_req_valid, mem_req_rw, mem_req_mask, d_stall} !== 7'b1_1_1111_1 ||
          mem_req_addr !== 32'h100 || mem_req_data !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_issue: v%b rw%b m%h st%b a%h d%h want v1 rw1 mF st1 a100 dDEADBEEF",
                  mem_req_valid, mem_req_rw, mem_req_mask, d_stall,
                  mem_req_addr, mem_req_data);
      end
      tick();
      n_chk++;
      if ({d_stall, mem_req_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL wr_done: stall,valid %b want 00", {d_stall, mem_req_valid});
      end
      d_we = 0;
      mem_req_ready = 0;
      tick();
   endtask

   task automatic test_fetch_read();
      i_re = 1; i_addr = 32'h40;
      #1;
      n_chk++;
      if (i_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_idle_stall: got %b want 1", i_stall);
      end
      tick();
      n_chk++;
      if ({mem_req_valid, mem_req_rw} !== 2'b10 || mem_req_addr !== 32'h40 ||
          mem_req_data !== 0 || mem_req_mask !== 0) begin
         n_fail++;
         $display("FAIL rd_issue: v%b rw%b a%h d%h m%h want v1 rw0 a40 d0 m0",
                  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask);
      end
      tick();
      tick();
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      n_chk++;
      if ({mem_req_valid, i_stall} !== 2'b01) begin
         n_fail++;
         $display("FAIL rd_wait: valid,stall %b want 01", {mem_req_valid, i_stall});
      end
      mem_resp_valid = 1; mem_resp_data = 32'h13;
      tick();
      mem_resp_valid = 0; mem_resp_data = 0;
      n_chk++;
      if (i_dout !== 32'h13 || i_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_done: i_dout %h stall %b want 13 0", i_dout, i_stall);
      end
      i_re = 0;
      tick();
   endtask

   task automatic test_arbitration();
      int g[3];
      int ng;
      int stall_bad;
      d_re = 1; d_addr = 32'h200;
      i_re = 1; i_addr = 32'h40;
      mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'h11111111;
      ng = 0;
      stall_bad = 0;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (mem_req_valid && ng < 3) begin
            g[ng] = (mem_req_addr == 32'h40) ? 1 : 0;
            ng++;
         end
         if (i_stall !== 1'b1) stall_bad++;
      end
      n_chk++;
      if (ng !== 3) begin
         n_fail++;
         $display("FAIL arb_count: grants %0d want 3", ng);
      end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      n_chk++;
      if (ng == 3 && (g[0] !== 0 || g[1] !== 1 || g[2] !== 0)) begin
         n_fail++;
         $display("FAIL arb_rr: seq %0d%0d%0d want 010", g[0], g[1], g[2]);
      end
`else
      n_chk++;
      if (ng == 3 && (g[0] !== 0 || g[1] !== 0 || g[2] !== 0)) begin
         n_fail++;
         $display("FAIL arb_fixed: seq %0d%0d%0d want 000", g[0], g[1], g[2]);
      end
      n_chk++;
      if (stall_bad !== 0) begin
         n_fail++;
         $display("FAIL arb_istall: %0d cycles low want 0", stall_bad);
      end
`endif
      do_reset();
   endtask

   task automatic test_reset_in_wait();
      d_re = 1; d_addr = 32'h300;
      mem_req_ready = 1;
      tick();
      tick();
      n_chk++;
      if ({mem_req_valid, d_stall} !== 2'b01) begin
         n_fail++;
         $display("FAIL rst_pre_wait: valid,stall %b want 01", {mem_req_valid, d_stall});
      end
      rst_n = 0;
      #1;
      n_chk++;
      if ({mem_req_valid, mem_req_rw} !== 2'b00 || mem_req_addr !== 0 ||
          d_dout !== 0 || i_dout !== 0) begin
         n_fail++;
         $display("FAIL rst_async: v%b rw%b a%h d%h i%h want all 0",
                  mem_req_valid, mem_req_rw, mem_req_addr, d_dout, i_dout);
      end
      d_re = 0; mem_req_ready = 0;
      tick();
      rst_n = 1;
      mem_resp_valid = 1; mem_resp_data = 32'hCAFEF00D;
      tick();
      tick();
      mem_resp_valid = 0; mem_resp_data = 0;
      n_chk++;
      if (d_dout !== 0 || mem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_late_resp: d_dout %h valid %b want 0 0", d_dout, mem_req_valid);
      end
   endtask

   task automatic test_read_then_masked_write();
      d_re = 1; d_addr = 32'h104;
      mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'hA5A5A5A5;
      tick();
      tick();
      tick();
      n_chk++;
      if (d_dout !== 32'hA5A5A5A5 || d_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL drd_done: d_dout %h stall %b want A5A5A5A5 0", d_dout, d_stall);
      end
      d_we = 4'b0011; d_din = 32'h12345678;
      mem_resp_data = 32'h0BADBAD0;
      tick();
      tick();
      n_chk++;
      if ({mem_req_valid, mem_req_rw, mem_req_mask} !== 6'b1_1_0011 ||
          mem_req_data !== 32'h12345678 || mem_req_addr !== 32'h104) begin
         n_fail++;
         $display("FAIL mwr_issue: v%b rw%b m%h d%h a%h want v1 rw1 m3 d12345678 a104",
                  mem_req_valid, mem_req_rw, mem_req_mask, mem_req_data, mem_req_addr);
      end
      tick();
      n_chk++;
      if (d_stall !== 1'b0 || d_dout !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL mwr_done: stall %b d_dout %h want 0 A5A5A5A5", d_stall, d_dout);
      end
      clear_inputs();
      tick();
   endtask

   initial begin
      clk = 0;
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_data_write();
      test_fetch_read();
      test_arbitration();
      test_reset_in_wait();
      test_read_then_masked_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
